// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
// Imported by the interface, the baud tick generator and the receiver top.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int OS_CNT_W   = $clog2(OVERSAMPLE);
    localparam int BIT_CNT_W  = 3;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] idx);
        return idx == BIT_CNT_W'(DATA_W - 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Serial input plus byte holding-register handshake of the UART receiver.
// The receiver is the slave; the consumer/line driver is the master.
interface uart_rx_byte_if;
    import uart_rx_pkg::*;

    logic              uart_rx;
    logic              rd_ack;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              overrun;
    logic              rx_busy;

    modport master (
        output uart_rx,
        output rd_ack,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  rx_busy
    );

    modport slave (
        input  uart_rx,
        input  rd_ack,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output rx_busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every CLK_DIV clocks.
// Free-running, but forced back to zero by restart to align ticks to a start edge.
module uart_baud_tick #(
    parameter int CLK_DIV = 326
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_W'(CLK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a single
// holding register with valid/ack handshake, framing-error and overrun flags.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = 326
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_byte_if.slave bus
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_BREAK = BREAK;

    localparam logic [OS_CNT_W-1:0] OS_HALF = OS_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_CNT_W-1:0] OS_FULL = OS_CNT_W'(OVERSAMPLE - 1);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [OS_CNT_W-1:0]  r_os_cnt;
    logic [BIT_CNT_W-1:0] r_bit_idx;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_restart;
    logic                 w_os_half;
    logic                 w_os_full;
    logic                 w_deliver;
    logic                 w_ack;

    // NOTE: synchronizer flops reset to 1 so reset release looks like an idle
    // line rather than a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_restart = (r_state == S_IDLE) && !r_rx_s;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    assign w_os_half = (r_os_cnt == OS_HALF);
    assign w_os_full = (r_os_cnt == OS_FULL);
    assign w_deliver = w_tick && (r_state == S_STOP) && w_os_full && r_rx_s;
    assign w_ack     = bus.rd_ack && r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_os_cnt    <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state  <= S_START;
                        r_os_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (w_os_half) begin
                            r_os_cnt <= '0;
                            if (r_rx_s) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state   <= S_DATA;
                                r_bit_idx <= '0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (w_os_full) begin
                            r_os_cnt           <= '0;
                            r_shift[r_bit_idx] <= r_rx_s;
                            if (is_last_bit(r_bit_idx)) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (w_os_full) begin
                            r_os_cnt <= '0;
                            if (r_rx_s) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                // Wait out a held-low line so it cannot be re-read as frames.
                S_BREAK: begin
                    if (w_tick && r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A delivery coinciding with an ack is a normal load, never an overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_deliver && (!r_valid || bus.rd_ack)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_ack) begin
                r_valid <= 1'b0;
            end

            if (w_deliver && r_valid && !bus.rd_ack) begin
                r_overrun <= 1'b1;
            end else if (w_ack) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.rx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLK_DIV=4 (64 clk per bit).
// Expected bytes are queued when a frame is sent and popped when the byte appears.
module tb_uart_rx_byte;

    localparam int BIT_CLKS = 64;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   fe_cnt;
    int   dv_rise;
    logic dv_q;
    int   start_cyc;
    int   fe_before;
    logic [7:0] sb_q[$];

    uart_rx_byte_if bus ();

    uart_rx_byte #(
        .CLK_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.frame_err) fe_cnt++;
        if (bus.data_valid && !dv_q) dv_rise = cyc;
        dv_q = bus.data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first and stop; rd_ack pulses on clock ack_at.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at,
                              input int n_clk);
        logic [9:0] fr;
        fr        = {stop, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < n_clk; i++) begin
            bus.uart_rx = fr[i / BIT_CLKS];
            bus.rd_ack  = (i == ack_at);
            @(negedge clk);
        end
        bus.rd_ack = 1'b0;
    endtask

    task automatic expect_byte(input string tag);
        logic [7:0] exp;
        check({tag, "_valid"}, bus.data_valid, 1'b1);
        check({tag, "_sb"}, (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check({tag, "_data"}, bus.data_out, exp);
        end
    endtask

    task automatic ack_pulse();
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        fe_cnt  = 0;
        dv_rise = 0;
        dv_q    = 1'b0;
        bus.uart_rx = 1'b1;
        bus.rd_ack  = 1'b0;
        rst = 1'b1;

        // Reset with a toggling line
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.uart_rx = i[0];
            @(negedge clk);
        end
        check("rst_valid", bus.data_valid, 1'b0);
        check("rst_data", bus.data_out, 8'h00);
        check("rst_ferr", bus.frame_err, 1'b0);
        check("rst_ovr", bus.overrun, 1'b0);
        check("rst_busy", bus.rx_busy, 1'b0);
        bus.uart_rx = 1'b1;
        rst = 1'b1;
        idle(200);
        check("idle_valid", bus.data_valid, 1'b0);
        check("idle_busy", bus.rx_busy, 1'b0);
        check("idle_ferr_cnt", fe_cnt, 0);

        // Plain byte receive and ack
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, 10 * BIT_CLKS);
        check("a5_latency", ((dv_rise - start_cyc) >= 600) && ((dv_rise - start_cyc) <= 620), 1'b1);
        expect_byte("a5");
        check("a5_no_ferr", fe_cnt, 0);
        check("a5_busy", bus.rx_busy, 1'b0);
        ack_pulse();
        check("a5_ack_valid", bus.data_valid, 1'b0);

        // False start
        bus.uart_rx = 1'b0;
        idle(10);
        check("fs_busy_on", bus.rx_busy, 1'b1);
        idle(10);
        bus.uart_rx = 1'b1;
        idle(60);
        check("fs_busy_off", bus.rx_busy, 1'b0);
        check("fs_valid", bus.data_valid, 1'b0);
        check("fs_ferr_cnt", fe_cnt, 0);

        // Framing error followed by a held-low line
        fe_before = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, 10 * BIT_CLKS);
        idle(200);
        check("fe_break_busy", bus.rx_busy, 1'b1);
        bus.uart_rx = 1'b1;
        idle(20);
        check("fe_pulses", fe_cnt - fe_before, 1);
        check("fe_valid", bus.data_valid, 1'b0);
        check("fe_busy_off", bus.rx_busy, 1'b0);
        sb_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, -1, 10 * BIT_CLKS);
        expect_byte("after_fe");
        ack_pulse();

        // Overrun: second byte lost, first kept
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, 10 * BIT_CLKS);
        check("ovr_first_ovr", bus.overrun, 1'b0);
        send_frame(8'h22, 1'b1, -1, 10 * BIT_CLKS);
        expect_byte("ovr_keep");
        check("ovr_set", bus.overrun, 1'b1);
        ack_pulse();
        check("ovr_ack_valid", bus.data_valid, 1'b0);
        check("ovr_ack_clear", bus.overrun, 1'b0);
        sb_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, -1, 10 * BIT_CLKS);
        expect_byte("after_ovr");
        check("after_ovr_flag", bus.overrun, 1'b0);
        ack_pulse();

        // Ack coinciding with the load of the next byte
        sb_q.push_back(8'h44);
        send_frame(8'h44, 1'b1, -1, 10 * BIT_CLKS);
        expect_byte("co_first");
        sb_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 610, 10 * BIT_CLKS);
        expect_byte("co_second");
        check("co_ovr", bus.overrun, 1'b0);

        // Reset in the middle of the data bits
        fe_before = fe_cnt;
        send_frame(8'h77, 1'b1, -1, 200);
        check("mr_busy", bus.rx_busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mr_valid", bus.data_valid, 1'b0);
        check("mr_data", bus.data_out, 8'h00);
        check("mr_busy_off", bus.rx_busy, 1'b0);
        check("mr_ovr", bus.overrun, 1'b0);
        bus.uart_rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idle(200);
        check("mr_after_valid", bus.data_valid, 1'b0);
        check("mr_after_ferr", fe_cnt - fe_before, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
